// File: rtl/stat_bench_pkg.sv
// Shared types and constants for the Stat_* benchmark harness: FSM states,
// default MISR polynomial/seed, and the one-step MISR update used by stimulus generators.
package stat_bench_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [31:0] din,
                                              input logic [31:0] poly);
        return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ din;
    endfunction

endpackage

// File: rtl/stat_misr.sv
// Multiple-input signature register: shifts left with polynomial feedback from the
// MSB and folds in one response word per enabled cycle; load restores the seed.
module stat_misr import stat_bench_pkg::*; #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = DEF_POLY,
    parameter logic [WIDTH-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
        end
    end

endmodule

// File: rtl/stat_response_compactor.sv
// Reader side of the benchmark harness: compacts response words into a MISR signature,
// counts patterns and CHANGED flags, and compares the final signature against a golden value.
module stat_response_compactor import stat_bench_pkg::*; #(
    parameter int               WIDTH = 32,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] POLY  = DEF_POLY,
    parameter logic [WIDTH-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] golden,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] pat_count,
    output logic [CNT_W-1:0] changed_count
);

    state_t           state;
    logic [CNT_W-1:0] num_q;
    logic [WIDTH-1:0] golden_q;
    logic             start_ok;
    logic             xfer;

    assign start_ok = start && (state == IDLE);
    assign xfer     = resp_valid && resp_ready;

    stat_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .en   (xfer),
        .din  (resp_data),
        .sig  (signature)
    );

    // resp_ready/busy/done are registered alongside the state so they never depend on resp_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            resp_ready    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            pat_count     <= '0;
            changed_count <= '0;
            num_q         <= '0;
            golden_q      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q         <= num_patterns;
                        golden_q      <= golden;
                        pat_count     <= '0;
                        changed_count <= '0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        if (num_patterns == '0) begin
                            state      <= COMPARE;
                            resp_ready <= 1'b0;
                        end else begin
                            state      <= CAPTURE;
                            resp_ready <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (xfer) begin
                        pat_count <= pat_count + CNT_W'(1);
                        if (resp_data[0]) begin
                            changed_count <= changed_count + CNT_W'(1);
                        end
                        if (pat_count + CNT_W'(1) == num_q) begin
                            state      <= COMPARE;
                            resp_ready <= 1'b0;
                        end
                    end
                end
                COMPARE: begin
                    pass  <= (signature == golden_q);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    resp_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stat_response_compactor.sv
// Self-checking bench for stat_response_compactor: directed runs plus randomized runs,
// each checked against a word-list reference model of the MISR and counters.
module tb_stat_response_compactor;
    import stat_bench_pkg::*;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_patterns;
    logic [W-1:0]  golden;
    logic          resp_valid;
    logic [W-1:0]  resp_data;
    logic          resp_ready;
    logic          busy;
    logic          done;
    logic          pass;
    logic [W-1:0]  signature;
    logic [CW-1:0] pat_count;
    logic [CW-1:0] changed_count;

    int total = 0;
    int bad   = 0;

    stat_response_compactor dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_patterns  (num_patterns),
        .golden        (golden),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_ready    (resp_ready),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .signature     (signature),
        .pat_count     (pat_count),
        .changed_count (changed_count)
    );

    always #5 clk = ~clk;

    // Signature of a whole word list: multiply by x modulo POLY, then add the word.
    function automatic logic [W-1:0] modelSig(input logic [W-1:0] words[$]);
        logic [W:0]   acc;
        logic [W-1:0] s;
        acc = {1'b0, DEF_SEED};
        foreach (words[i]) begin
            acc = {1'b0, acc[W-1:0]} * 33'd2;
            s   = acc[W] ? (acc[W-1:0] ^ DEF_POLY) : acc[W-1:0];
            acc = {1'b0, s ^ words[i]};
        end
        return acc[W-1:0];
    endfunction

    function automatic int modelChanged(input logic [W-1:0] words[$]);
        int c = 0;
        foreach (words[i]) if (words[i][0]) c++;
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"},   resp_ready,    0);
        checkOutput({tag, "_busy"},    busy,          0);
        checkOutput({tag, "_done"},    done,          0);
        checkOutput({tag, "_pass"},    pass,          0);
        checkOutput({tag, "_sig"},     signature,     DEF_SEED);
        checkOutput({tag, "_pat"},     pat_count,     0);
        checkOutput({tag, "_changed"}, changed_count, 0);
    endtask

    // One full run: start, feed words with the chosen valid pattern, then check COMPARE/DONE/hold.
    // mode 0: valid always, 1: valid alternates starting high, 2: random valid.
    task automatic applyStimulus(input string name, input logic [W-1:0] words[$], input bit goldMatch,
                                 input int mode, input bit validWithStart, input bit injectStart);
        int           n;
        int           sent;
        int           iter;
        logic [W-1:0] expSig;
        logic [W-1:0] gold;
        n      = words.size();
        sent   = 0;
        iter   = 0;
        expSig = modelSig(words);
        gold   = goldMatch ? expSig : (expSig ^ (32'h1 << $urandom_range(31)));

        @(negedge clk);
        start        = 1'b1;
        num_patterns = n[CW-1:0];
        golden       = gold;
        resp_valid   = validWithStart;
        resp_data    = $urandom;
        @(negedge clk);
        start      = 1'b0;
        resp_valid = 1'b0;
        checkOutput({name, "_pass_clr"}, pass, 0);
        checkOutput({name, "_ready_on"}, resp_ready, (n != 0) ? 1 : 0);
        checkOutput({name, "_busy_on"},  busy, 1);

        while (sent < n && iter < 400) begin
            case (mode)
                0:       resp_valid = 1'b1;
                1:       resp_valid = (iter % 2 == 0);
                default: resp_valid = 1'($urandom_range(1));
            endcase
            resp_data = words[sent];
            if (injectStart && iter == 1) begin
                start        = 1'b1;
                num_patterns = CW'(n + 5);
                golden       = ~gold;
            end else begin
                start = 1'b0;
            end
            if (resp_valid && resp_ready) sent++;
            iter++;
            @(negedge clk);
        end
        start      = 1'b0;
        resp_valid = 1'b0;
        resp_data  = $urandom;
        checkOutput({name, "_all_sent"}, sent, n);

        checkOutput({name, "_cmp_ready"}, resp_ready, 0);
        checkOutput({name, "_cmp_busy"},  busy, 1);
        checkOutput({name, "_cmp_done"},  done, 0);
        checkOutput({name, "_cmp_pat"},   pat_count, n);

        @(negedge clk);
        checkOutput({name, "_done"},    done, 1);
        checkOutput({name, "_dn_busy"}, busy, 0);
        checkOutput({name, "_pass"},    pass, goldMatch ? 1 : 0);
        checkOutput({name, "_sig"},     signature, expSig);
        checkOutput({name, "_pat"},     pat_count, n);
        checkOutput({name, "_changed"}, changed_count, modelChanged(words));

        @(negedge clk);
        checkOutput({name, "_done_off"},  done, 0);
        checkOutput({name, "_pass_hold"}, pass, goldMatch ? 1 : 0);
        checkOutput({name, "_idle_rdy"},  resp_ready, 0);
    endtask

    initial begin
        logic [W-1:0] words[$];
        rst          = 1'b1;
        start        = 1'b0;
        num_patterns = '0;
        golden       = '0;
        resp_valid   = 1'b0;
        resp_data    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("reset");

        // Single word with CHANGED set; seed FFFFFFFF gives FFFFFFFE^POLY^1.
        words = '{32'h0000_0001};
        applyStimulus("t1", words, 1'b1, 0, 1'b0, 1'b0);
        checkOutput("t1_sig_const", signature, 32'hFB3E_E248);
        checkOutput("t1_changed_const", changed_count, 1);

        words = '{32'h8000_0000, 32'h0000_0000};
        applyStimulus("t2", words, 1'b1, 0, 1'b0, 1'b0);

        words = '{$urandom, $urandom, $urandom};
        applyStimulus("t3", words, 1'b1, 1, 1'b0, 1'b0);

        words = '{};
        applyStimulus("t4", words, 1'b1, 0, 1'b0, 1'b0);
        checkOutput("t4_sig_seed", signature, 32'hFFFF_FFFF);
        applyStimulus("t4_miss", words, 1'b0, 0, 1'b0, 1'b0);

        // Reset in the middle of a 4-word run, after two transfers.
        @(negedge clk);
        start        = 1'b1;
        num_patterns = 16'd4;
        golden       = $urandom;
        @(negedge clk);
        start      = 1'b0;
        resp_valid = 1'b1;
        resp_data  = $urandom;
        @(negedge clk);
        resp_data = $urandom;
        @(negedge clk);
        resp_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetValues("t5_rst");
        words = '{32'h0000_0001};
        applyStimulus("t5_rerun", words, 1'b1, 0, 1'b0, 1'b0);

        words = '{$urandom, $urandom, $urandom, $urandom};
        applyStimulus("t6", words, 1'b1, 0, 1'b0, 1'b1);

        words = '{$urandom | 32'h1, $urandom};
        applyStimulus("t7_vstart", words, 1'b1, 0, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int nw;
            nw = $urandom_range(8, 1);
            words = '{};
            for (int k = 0; k < nw; k++) words.push_back($urandom);
            applyStimulus($sformatf("rnd%0d", r), words, 1'($urandom_range(1)), 2,
                          1'($urandom_range(1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
